axis_fifo_wr_ctrl: RTL and testbench

Write-side controller of the AXIS data FIFO: accepts AXI-Stream beats, generates memory write strobes and addresses, and publishes the write pointer as a registered Gray code for crossing into the read domain. It is the source end of the pointer crossing. It consumes the read pointer after it has passed through the pointer synchronizer, and derives `full`, `almost_full` and fill level from it. The block runs entirely in the write clock domain.

---
 rtl/axis_fifo_wr_ctrl.sv | 93 +++++++++
 tb/tb_axis_fifo_wr_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_wr_ctrl.sv
// Write-side controller of the AXIS FIFO: accepts beats, drives memory writes, publishes a registered Gray write pointer; level/almost_full built under AXIS_FIFO_WR_LEVEL_EN.
// Latency: memory write strobe/addr/data combinational with the beat; pointer, full, almost_full, level update one edge after the push.
// Backpressure: s_axis_tready = ~full, independent of tvalid; full is pessimistic as it sees the synchronized (delayed) read pointer.
module axis_fifo_wr_ctrl #(
    parameter int FIFO_DEPTH         = 16,
    parameter int DATA_WIDTH         = 32,
    parameter int ALMOST_FULL_THRESH = 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
    input  logic                           s_axis_tlast,
    output logic                           mem_wr_en,
    output logic [$clog2(FIFO_DEPTH)-1:0]  mem_wr_addr,
    output logic [DATA_WIDTH:0]            mem_wr_data,
    output logic [$clog2(FIFO_DEPTH):0]    wr_ptr_gray,
    input  logic [$clog2(FIFO_DEPTH):0]    rd_ptr_gray_sync,
    output logic                           full,
    output logic                           almost_full,
    output logic [$clog2(FIFO_DEPTH):0]    wr_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    if (FIFO_DEPTH < 4 || (1 << AW) != FIFO_DEPTH ||
        ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > FIFO_DEPTH) begin : g_bad_cfg
        $error("axis_fifo_wr_ctrl: illegal FIFO_DEPTH / ALMOST_FULL_THRESH");
    end

    logic          push;
    logic [PW-1:0] wr_bin;
    logic [PW-1:0] wr_bin_nxt;
    logic [PW-1:0] wr_gray_nxt;
    logic [PW-1:0] rd_gray_full;
    logic          full_nxt;

    assign push        = s_axis_tvalid & ~full;
    assign wr_bin_nxt  = wr_bin + {{AW{1'b0}}, push};
    assign wr_gray_nxt = wr_bin_nxt ^ (wr_bin_nxt >> 1);

    // Full when the write pointer is one lap ahead: in Gray that means the top two bits inverted.
    assign rd_gray_full = {~rd_ptr_gray_sync[PW-1:PW-2], rd_ptr_gray_sync[PW-3:0]};
    assign full_nxt     = (wr_gray_nxt == rd_gray_full);

    assign s_axis_tready = ~full;
    assign mem_wr_en     = push;
    assign mem_wr_addr   = wr_bin[AW-1:0];
    assign mem_wr_data   = {s_axis_tlast, s_axis_tdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bin      <= '0;
            wr_ptr_gray <= '0;
            full        <= 1'b0;
        end else begin
            wr_bin      <= wr_bin_nxt;
            wr_ptr_gray <= wr_gray_nxt;
            full        <= full_nxt;
        end
    end

`ifdef AXIS_FIFO_WR_LEVEL_EN
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] level_nxt;

    always_comb begin
        rd_bin         = '0;
        rd_bin[PW-1]   = rd_ptr_gray_sync[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            rd_bin[i] = rd_bin[i+1] ^ rd_ptr_gray_sync[i];
        end
    end

    assign level_nxt = wr_bin_nxt - rd_bin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_level    <= '0;
            almost_full <= 1'b0;
        end else begin
            wr_level    <= level_nxt;
            almost_full <= (level_nxt >= PW'(ALMOST_FULL_THRESH));
        end
    end
`else
    assign wr_level    = '0;
    assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_axis_fifo_wr_ctrl.sv
// Directed bench for axis_fifo_wr_ctrl: reset, fill to full, free one entry, async reset, pointer wrap.
module tb_axis_fifo_wr_ctrl;

    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int AFT   = 12;
    localparam int AW    = 4;
    localparam int PW    = 5;

`ifdef AXIS_FIFO_WR_LEVEL_EN
    localparam int LVL = 1;
`else
    localparam int LVL = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tlast;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW:0]   mem_wr_data;
    logic [PW-1:0] wr_ptr_gray;
    logic [PW-1:0] rd_ptr_gray_sync;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] wr_level;

    int n_chk = 0;
    int n_err = 0;

    axis_fifo_wr_ctrl #(
        .FIFO_DEPTH         (DEPTH),
        .DATA_WIDTH         (DW),
        .ALMOST_FULL_THRESH (AFT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tlast     (s_axis_tlast),
        .mem_wr_en        (mem_wr_en),
        .mem_wr_addr      (mem_wr_addr),
        .mem_wr_data      (mem_wr_data),
        .wr_ptr_gray      (wr_ptr_gray),
        .rd_ptr_gray_sync (rd_ptr_gray_sync),
        .full             (full),
        .almost_full      (almost_full),
        .wr_level         (wr_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] gray(input int b);
        logic [PW-1:0] x;
        x = b[PW-1:0];
        return x ^ (x >> 1);
    endfunction

    initial begin
        int            pulses;
        int            count;
        logic [PW-1:0] prev;
        logic [DW:0]   exp_data;

        rst              = 1'b1;
        s_axis_tvalid    = 1'b0;
        s_axis_tdata     = '0;
        s_axis_tlast     = 1'b0;
        rd_ptr_gray_sync = '0;

        #3;
        check("rst_full",  full,          0);
        check("rst_ready", s_axis_tready, 1);
        check("rst_gray",  wr_ptr_gray,   0);
        check("rst_level", wr_level,      0);
        check("rst_af",    almost_full,   0);
        tick;
        rst = 1'b0;

        // Fill: read pointer parked at 0, valid held for 20 cycles
        pulses        = 0;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_axis_tdata = 32'hA000_0000 + i;
            s_axis_tlast = (i == 15);
            #1;
            check("fill_wr_en", mem_wr_en, (i < 16) ? 1 : 0);
            if (i < 16) begin
                exp_data = {(i == 15) ? 1'b1 : 1'b0, 32'hA000_0000 + i};
                check("fill_addr", mem_wr_addr, i);
                check("fill_data", mem_wr_data, exp_data);
            end
            pulses += int'(mem_wr_en);
            tick;
            if (i < 15)  check("fill_not_full", full, 0);
            if (i >= 15) check("fill_ready_low", s_axis_tready, 0);
            if (i == 10) begin
                check("lvl11", wr_level, 11 * LVL);
                check("af11",  almost_full, 0);
            end
            if (i == 11) begin
                check("lvl12", wr_level, 12 * LVL);
                check("af12",  almost_full, LVL);
            end
            if (i == 15) begin
                check("full16", full, 1);
                check("gray16", wr_ptr_gray, 5'b11000);
            end
        end
        check("fill_pulses", pulses, 16);
        check("fill_lvl_end", wr_level, 16 * LVL);

        // Free one entry
        rd_ptr_gray_sync = 5'b00001;
        tick;
        check("free_full",  full, 0);
        check("free_lvl",   wr_level, 15 * LVL);
        check("free_ready", s_axis_tready, 1);
        check("free_wr_en", mem_wr_en, 1);
        check("free_addr",  mem_wr_addr, 0);
        tick;
        check("refull",       full, 1);
        check("refull_gray",  wr_ptr_gray, 5'b11001);
        check("refull_wr_en", mem_wr_en, 0);

        // Asynchronous reset mid-cycle
        #3;
        rst = 1'b1;
        #1;
        check("arst_full",  full,          0);
        check("arst_ready", s_axis_tready, 1);
        check("arst_gray",  wr_ptr_gray,   0);
        check("arst_level", wr_level,      0);
        check("arst_af",    almost_full,   0);
        s_axis_tvalid    = 1'b0;
        rd_ptr_gray_sync = '0;
        tick;
        rst = 1'b0;

        // Wrap: 40 beats, read pointer two behind
        count = 0;
        prev  = wr_ptr_gray;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rd_ptr_gray_sync = gray((count >= 2) ? count - 2 : 0);
            s_axis_tdata     = 32'h5500_0000 + i;
            #1;
            check("wrap_wr_en", mem_wr_en, 1);
            check("wrap_addr",  mem_wr_addr, count % DEPTH);
            tick;
            count++;
            check("wrap_onebit", $countones(wr_ptr_gray ^ prev), 1);
            check("wrap_gray",   wr_ptr_gray, gray(count));
            check("wrap_full",   full, 0);
            prev = wr_ptr_gray;
        end
        check("wrap_lvl", wr_level, 3 * LVL);
        s_axis_tvalid = 1'b0;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
